// File: rtl/qdrc_arb.sv
// Two-requester round-robin arbiter in front of a single QDR controller user port.
// Read data is routed back through an in-order tag FIFO. Define QDRC_ARB_STATS_EN for issue counters.
module qdrc_arb #(
    parameter int DATA_WIDTH = 18,
    parameter int BW_WIDTH   = 2,
    parameter int ADDR_WIDTH = 21,
    parameter int TAG_DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    phy_rdy,
    input  logic                    p0_rd_strb,
    input  logic                    p0_wr_strb,
    input  logic [ADDR_WIDTH-1:0]   p0_addr,
    input  logic [2*DATA_WIDTH-1:0] p0_wr_data,
    input  logic [2*BW_WIDTH-1:0]   p0_wr_be,
    output logic                    p0_ack,
    output logic [2*DATA_WIDTH-1:0] p0_rd_data,
    output logic                    p0_rd_dvld,
    input  logic                    p1_rd_strb,
    input  logic                    p1_wr_strb,
    input  logic [ADDR_WIDTH-1:0]   p1_addr,
    input  logic [2*DATA_WIDTH-1:0] p1_wr_data,
    input  logic [2*BW_WIDTH-1:0]   p1_wr_be,
    output logic                    p1_ack,
    output logic [2*DATA_WIDTH-1:0] p1_rd_data,
    output logic                    p1_rd_dvld,
    output logic                    usr_rd_strb,
    output logic                    usr_wr_strb,
    output logic [ADDR_WIDTH-1:0]   usr_addr,
    output logic [2*DATA_WIDTH-1:0] usr_wr_data,
    output logic [2*BW_WIDTH-1:0]   usr_wr_be,
    input  logic [2*DATA_WIDTH-1:0] usr_rd_data,
    input  logic                    usr_rd_dvld,
    output logic                    err_underflow,
    output logic [31:0]             rd_cnt,
    output logic [31:0]             wr_cnt
);

    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(TAG_DEPTH);

    typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;

    port_e                   last_grant;
    port_e                   grant;
    port_e                   tag_mem [TAG_DEPTH];
    port_e                   head;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           tag_cnt;
    logic                    can_rd;
    logic                    elig0;
    logic                    elig1;
    logic                    any_grant;
    logic                    sel_wr;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [2*DATA_WIDTH-1:0] sel_data;
    logic [2*BW_WIDTH-1:0]   sel_be;
    logic                    issue_rd;
    logic                    issue_wr;
    logic                    push;
    logic                    pop;

    always_comb begin
        can_rd    = (tag_cnt != FULL);
        elig0     = phy_rdy & (p0_wr_strb | (p0_rd_strb & can_rd));
        elig1     = phy_rdy & (p1_wr_strb | (p1_rd_strb & can_rd));
        any_grant = elig0 | elig1;
        grant     = PORT0;
        if (elig0 && elig1)
            grant = (last_grant == PORT0) ? PORT1 : PORT0;
        else if (elig1)
            grant = PORT1;
        p0_ack = elig0 && (grant == PORT0);
        p1_ack = elig1 && (grant == PORT1);
        // A port holding both strobes gets its write first; the read stays pending.
        sel_wr   = (grant == PORT0) ? p0_wr_strb : p1_wr_strb;
        sel_addr = (grant == PORT0) ? p0_addr    : p1_addr;
        sel_data = (grant == PORT0) ? p0_wr_data : p1_wr_data;
        sel_be   = (grant == PORT0) ? p0_wr_be   : p1_wr_be;
        issue_wr = any_grant & sel_wr;
        issue_rd = any_grant & ~sel_wr;
        push     = issue_rd;
        pop      = usr_rd_dvld & (tag_cnt != '0);
        head     = tag_mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr] <= grant;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant    <= PORT1;
            usr_rd_strb   <= 1'b0;
            usr_wr_strb   <= 1'b0;
            usr_addr      <= '0;
            usr_wr_data   <= '0;
            usr_wr_be     <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            tag_cnt       <= '0;
            p0_rd_dvld    <= 1'b0;
            p1_rd_dvld    <= 1'b0;
            p0_rd_data    <= '0;
            p1_rd_data    <= '0;
            err_underflow <= 1'b0;
        end else begin
            usr_rd_strb <= issue_rd;
            usr_wr_strb <= issue_wr;
            if (any_grant) begin
                last_grant  <= grant;
                usr_addr    <= sel_addr;
                usr_wr_data <= sel_data;
                usr_wr_be   <= sel_be;
            end
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   tag_cnt <= tag_cnt + 1'b1;
                2'b01:   tag_cnt <= tag_cnt - 1'b1;
                default: tag_cnt <= tag_cnt;
            endcase
            p0_rd_dvld <= pop && (head == PORT0);
            p1_rd_dvld <= pop && (head == PORT1);
            if (pop && head == PORT0)
                p0_rd_data <= usr_rd_data;
            if (pop && head == PORT1)
                p1_rd_data <= usr_rd_data;
            if (usr_rd_dvld && tag_cnt == '0)
                err_underflow <= 1'b1;
        end
    end

`ifdef QDRC_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (issue_rd)
                rd_cnt <= rd_cnt + 32'd1;
            if (issue_wr)
                wr_cnt <= wr_cnt + 32'd1;
        end
    end
`else
    assign rd_cnt = '0;
    assign wr_cnt = '0;
`endif

endmodule

// File: tb/tb_qdrc_arb.sv
// Directed self-checking bench for qdrc_arb; read returns are tracked by a tag model and a return scoreboard.
module tb_qdrc_arb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        phy_rdy;
    logic        p0_rd_strb, p0_wr_strb, p1_rd_strb, p1_wr_strb;
    logic [20:0] p0_addr, p1_addr, usr_addr;
    logic [35:0] p0_wr_data, p1_wr_data, p0_rd_data, p1_rd_data;
    logic [35:0] usr_wr_data, usr_rd_data;
    logic [3:0]  p0_wr_be, p1_wr_be, usr_wr_be;
    logic        p0_ack, p1_ack, p0_rd_dvld, p1_rd_dvld;
    logic        usr_rd_strb, usr_wr_strb, usr_rd_dvld, err_underflow;
    logic [31:0] rd_cnt, wr_cnt;

    typedef struct {
        logic        valid;
        logic        port;
        logic [35:0] data;
    } ret_t;

    bit          tagq [$];
    ret_t        retq [$];
    logic [20:0] addrq [$];
    int          n_checks = 0;
    int          n_fail = 0;

`ifdef QDRC_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    always #5 clk = ~clk;

    qdrc_arb #(.DATA_WIDTH(18), .BW_WIDTH(2), .ADDR_WIDTH(21), .TAG_DEPTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .phy_rdy(phy_rdy),
        .p0_rd_strb(p0_rd_strb), .p0_wr_strb(p0_wr_strb), .p0_addr(p0_addr),
        .p0_wr_data(p0_wr_data), .p0_wr_be(p0_wr_be), .p0_ack(p0_ack),
        .p0_rd_data(p0_rd_data), .p0_rd_dvld(p0_rd_dvld),
        .p1_rd_strb(p1_rd_strb), .p1_wr_strb(p1_wr_strb), .p1_addr(p1_addr),
        .p1_wr_data(p1_wr_data), .p1_wr_be(p1_wr_be), .p1_ack(p1_ack),
        .p1_rd_data(p1_rd_data), .p1_rd_dvld(p1_rd_dvld),
        .usr_rd_strb(usr_rd_strb), .usr_wr_strb(usr_wr_strb), .usr_addr(usr_addr),
        .usr_wr_data(usr_wr_data), .usr_wr_be(usr_wr_be),
        .usr_rd_data(usr_rd_data), .usr_rd_dvld(usr_rd_dvld),
        .err_underflow(err_underflow), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ret();
        ret_t e;
        e.valid = 1'b0;
        e.port  = 1'b0;
        e.data  = '0;
        if (retq.size() != 0)
            e = retq.pop_front();
        chk("p0_rd_dvld", p0_rd_dvld, e.valid && !e.port);
        chk("p1_rd_dvld", p1_rd_dvld, e.valid && e.port);
        if (e.valid)
            chk("rd_data", e.port ? p1_rd_data : p0_rd_data, e.data);
    endtask

    // Every cycle: advance past the edge, check return routing, release the controller return.
    task automatic tick();
        @(posedge clk);
        #1;
        check_ret();
        usr_rd_dvld = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_return(input logic [35:0] data);
        ret_t e;
        usr_rd_dvld = 1'b1;
        usr_rd_data = data;
        e.data = data;
        if (tagq.size() != 0) begin
            e.valid = 1'b1;
            e.port  = tagq.pop_front();
        end else begin
            e.valid = 1'b0;
            e.port  = 1'b0;
        end
        retq.push_back(e);
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        p0_rd_strb = 1'b0; p0_wr_strb = 1'b0; p1_rd_strb = 1'b0; p1_wr_strb = 1'b0;
        usr_rd_dvld = 1'b0;
        tagq.delete();
        retq.delete();
        #3;
        chk("rst_err", err_underflow, 1'b0);
        chk("rst_usr_rd", usr_rd_strb, 1'b0);
        chk("rst_usr_wr", usr_wr_strb, 1'b0);
        chk("rst_rd_cnt", rd_cnt, 32'd0);
        reset_n = 1'b1;
    endtask

    // Single-port request; assumes the other port is idle.
    task automatic issue(input bit port, input bit wr, input logic [20:0] addr, input logic [35:0] data);
        if (port) begin
            p1_wr_strb = wr; p1_rd_strb = !wr; p1_addr = addr; p1_wr_data = data;
        end else begin
            p0_wr_strb = wr; p0_rd_strb = !wr; p0_addr = addr; p0_wr_data = data;
        end
        settle();
        chk("issue_p0_ack", p0_ack, !port);
        chk("issue_p1_ack", p1_ack, port);
        if (!wr)
            tagq.push_back(port);
        tick();
        p0_wr_strb = 1'b0; p0_rd_strb = 1'b0; p1_wr_strb = 1'b0; p1_rd_strb = 1'b0;
        chk("issue_usr_wr", usr_wr_strb, wr);
        chk("issue_usr_rd", usr_rd_strb, !wr);
        chk("issue_addr", usr_addr, addr);
        if (wr)
            chk("issue_data", usr_wr_data, data);
    endtask

    initial begin
        reset_n = 1'b0; phy_rdy = 1'b0;
        p0_rd_strb = 0; p0_wr_strb = 0; p1_rd_strb = 0; p1_wr_strb = 0;
        p0_addr = '0; p1_addr = '0; p0_wr_data = '0; p1_wr_data = '0;
        p0_wr_be = 4'hF; p1_wr_be = 4'h3; usr_rd_data = '0; usr_rd_dvld = 0;
        #12;
        chk("reset_addr", usr_addr, 21'd0);
        chk("reset_p0_ack", p0_ack, 1'b0);
        do_reset();

        // 1: no grants while the controller is not calibrated
        p0_wr_strb = 1'b1; p0_addr = 21'h111; p0_wr_data = 36'h123456789;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t1_no_ack", p0_ack, 1'b0);
            chk("t1_no_wr", usr_wr_strb, 1'b0);
        end
        phy_rdy = 1'b1;
        settle();
        chk("t1_ack", p0_ack, 1'b1);
        tick();
        p0_wr_strb = 1'b0;
        chk("t1_usr_wr", usr_wr_strb, 1'b1);
        chk("t1_addr", usr_addr, 21'h111);
        chk("t1_be", usr_wr_be, 4'hF);
        tick();
        chk("t1_wr_pulse", usr_wr_strb, 1'b0);
        chk("t1_addr_hold", usr_addr, 21'h111);

        // 2: alternating grants after reset
        do_reset();
        p0_wr_strb = 1'b1; p0_addr = 21'h0A0;
        p1_wr_strb = 1'b1; p1_addr = 21'h0B0;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("t2_p0_ack", p0_ack, (i % 2) == 0);
            chk("t2_p1_ack", p1_ack, (i % 2) == 1);
            addrq.push_back((i % 2) == 0 ? 21'h0A0 : 21'h0B0);
            tick();
            chk("t2_usr_wr", usr_wr_strb, 1'b1);
            chk("t2_addr", usr_addr, addrq.pop_front());
        end
        p0_wr_strb = 1'b0; p1_wr_strb = 1'b0;

        // 3: two reads, returns routed in order; phy_rdy low during drain
        p0_rd_strb = 1'b1; p0_addr = 21'h10;
        p1_rd_strb = 1'b1; p1_addr = 21'h20;
        settle();
        chk("t3_p0_ack", p0_ack, 1'b1);
        chk("t3_p1_wait", p1_ack, 1'b0);
        tagq.push_back(1'b0);
        tick();
        p0_rd_strb = 1'b0;
        chk("t3_usr_rd0", usr_rd_strb, 1'b1);
        chk("t3_addr0", usr_addr, 21'h10);
        settle();
        chk("t3_p1_ack", p1_ack, 1'b1);
        tagq.push_back(1'b1);
        tick();
        p1_rd_strb = 1'b0;
        chk("t3_addr1", usr_addr, 21'h20);
        phy_rdy = 1'b0;
        repeat (3) tick();
        drive_return(36'hD0D0D0D00);
        tick();
        drive_return(36'hD1D1D1D11);
        tick();
        tick();
        phy_rdy = 1'b1;

        // 4: tag FIFO full blocks reads, even when a pop lands the same cycle
        p0_rd_strb = 1'b1;
        for (int i = 0; i < 16; i++) begin
            p0_addr = 21'(32'h100 + i);
            settle();
            chk("t4_fill_ack", p0_ack, 1'b1);
            tagq.push_back(1'b0);
            tick();
        end
        settle();
        chk("t4_full", p0_ack, 1'b0);
        tick();
        drive_return(36'hABC);
        settle();
        chk("t4_full_pop", p0_ack, 1'b0);
        tick();
        settle();
        chk("t4_after_pop", p0_ack, 1'b1);
        tagq.push_back(1'b0);
        tick();
        p0_rd_strb = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_return(36'(32'h500 + i));
            tick();
        end
        tick();

        // 5: read+write together -> write first, read on a later ack
        p1_wr_strb = 1'b1; p1_rd_strb = 1'b1; p1_addr = 21'h5; p1_wr_data = 36'h55;
        settle();
        chk("t5_wr_ack", p1_ack, 1'b1);
        tick();
        p1_wr_strb = 1'b0;
        chk("t5_usr_wr", usr_wr_strb, 1'b1);
        chk("t5_usr_rd_lo", usr_rd_strb, 1'b0);
        chk("t5_wdata", usr_wr_data, 36'h55);
        settle();
        chk("t5_rd_ack", p1_ack, 1'b1);
        tagq.push_back(1'b1);
        tick();
        p1_rd_strb = 1'b0;
        chk("t5_usr_rd", usr_rd_strb, 1'b1);
        chk("t5_usr_wr_lo", usr_wr_strb, 1'b0);
        chk("t5_addr", usr_addr, 21'h5);
        drive_return(36'h777);
        tick();

        // 6: underflow is sticky, counters, stale return after reset
        chk("t6_err_clear", err_underflow, 1'b0);
        drive_return(36'hBAD);
        tick();
        chk("t6_err_set", err_underflow, 1'b1);
        repeat (2) tick();
        chk("t6_err_sticky", err_underflow, 1'b1);
        do_reset();
        for (int i = 0; i < 3; i++)
            issue(1'b0, 1'b1, 21'(32'h40 + i), 36'(32'h900 + i));
        for (int i = 0; i < 2; i++)
            issue(1'b0, 1'b0, 21'(32'h60 + i), '0);
        chk("t6_wr_cnt", wr_cnt, STATS ? 32'd3 : 32'd0);
        chk("t6_rd_cnt", rd_cnt, STATS ? 32'd2 : 32'd0);
        do_reset();
        drive_return(36'h5A1E);
        tick();
        chk("t6_stale_err", err_underflow, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
